uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised UART receiver with start-bit glitch rejection, selectable word length and parity, line-error reporting and a show-ahead receive FIFO with a ready/valid read port. It is the next-generation receive side of the board UART and feeds the core's program/data loader, which drains bytes at its own pace. Default parameters give 9600 baud 8N1 at the 100 MHz board clock.

## Interface
- CLK_PER_HALF_BIT, 5208, clock cycles per half bit period; minimum 2
- DATA_BITS, 8, data bits per frame, 5 to 9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- FIFO_DEPTH, 16, receive FIFO entries, power of two, minimum 2
- clk  in  1  single system clock, all logic on rising edge
- rstn  in  1  asynchronous, active-low reset
- rxd  in  1  serial line, idle high, asynchronous to clk
- rd_data  out  DATA_BITS  FIFO head word, valid when rd_valid
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts rd_data when rd_valid & rd_ready
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- frame_err  out  1  sticky: stop bit sampled low
- parity_err  out  1  sticky: parity mismatch
- overrun_err  out  1  sticky: completed word dropped, FIFO full
- err_clr  in  1  synchronous clear of all three sticky flags

## Operation
- rxd passes through a 2-flop synchroniser (reset to 1); all logic uses the synchronised value rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rx_s == 0, load baud counter, go START.
- START: after CLK_PER_HALF_BIT cycles sample mid-bit; rx_s == 0 -> DATA, rx_s == 1 -> IDLE (glitch, no flag, nothing stored).
- DATA: sample every 2*CLK_PER_HALF_BIT cycles, LSB first, into shift register; after DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
- PARITY: one sample; compared with XOR of data (even) or its inverse (odd); mismatch remembered for this frame.
- STOP: one sample. rx_s == 1 and no parity mismatch -> push word, IDLE. rx_s == 1 with mismatch -> set parity_err, drop word, IDLE. rx_s == 0 -> set frame_err, drop word, BREAK (parity mismatch in the same frame also sets parity_err).
- BREAK: wait for rx_s == 1, then IDLE; prevents a held-low line producing repeated frames.
- FIFO push when full and no pop in the same cycle: word dropped, overrun_err set, contents unchanged.
- Push and pop in the same cycle: both take effect, including at full (count unchanged) and at count 1 (new word becomes head).
- Pop on empty (rd_ready with rd_valid low): ignored.
- err_clr has priority over a same-cycle error set only for flags not being set that cycle; a flag set and cleared in the same cycle ends set.
- Pointers wrap modulo FIFO_DEPTH; count saturates neither way (guarded by full/empty).

## Timing
- Reset values: rd_valid 0, fifo_count 0, rd_data 0, all error flags 0, FSM IDLE, synchroniser 1.
- Reset mid-frame: frame abandoned, FIFO emptied; receiver restarts at next falling edge after rstn release.
- rxd-to-rx_s latency 2 cycles.
- Stop sample at 2 + CLK_PER_HALF_BIT + (DATA_BITS + P) * 2*CLK_PER_HALF_BIT cycles after rxd falls (P = 1 if parity enabled), ±1 for synchroniser phase.
- Word pushed on the stop-sample edge; rd_valid and fifo_count reflect it on the next cycle.
- Show-ahead read: rd_data is valid in the same cycle rd_valid is high; after a pop the next head appears the following cycle with no bubble.
- Error flags assert the cycle after the offending sample.
- Back-to-back frames: a start bit immediately after the stop-bit sample instant is detected (IDLE entered at mid-stop).

## Structure
- Package uart_pkg: parity mode constants (PAR_NONE, PAR_EVEN, PAR_ODD) and FSM state enumeration, shared with the future uart_tx generation.
- Sub-module sync_fifo (DATA_W, DEPTH): single-clock show-ahead FIFO with push/pop/full/empty/count, reused by the transmitter.
- Receiver FSM, baud counter and bit counter live in uart_rx_fifo itself.

## Test plan
- CLK_PER_HALF_BIT=8, 8N1, send 0xA5 -> rd_valid rises one cycle after stop sample, rd_data 0xA5, fifo_count 1; pop -> rd_valid 0.
- 4-cycle low pulse on rxd -> no word, no flag, FSM back to IDLE.
- PARITY=1, send 0x03 with parity bit 1 -> parity_err 1, FIFO empty; err_clr -> flag 0; send 0x03 with parity 0 -> stored.
- Hold rxd low 40 bit periods -> frame_err 1, exactly zero words stored, next valid frame 0x5A stored after line returns high.
- FIFO_DEPTH=4, send 0x10..0x14 with rd_ready 0 -> count 4, overrun_err 1, drain yields 0x10,0x11,0x12,0x13.
- DATA_BITS=7, PARITY=2, back-to-back 0x7F, 0x00 with rd_ready 1 and pop coinciding with second push -> both read in order, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode encodings and receiver FSM states.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; the head word is presented whenever the FIFO is non-empty.
module sync_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AddrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic              do_push, do_pop;

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  assign count = count_q;

  // A push at full is still accepted when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Empty FIFO presents zero so the read port is clean out of reset.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with start-glitch rejection, optional parity, sticky line errors and a
// show-ahead receive FIFO drained through a ready/valid port.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_PER_HALF_BIT = 5208,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned FIFO_DEPTH       = 16
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun_err,
  input  logic                          err_clr
);

  localparam int unsigned BaudW = $clog2(2 * CLK_PER_HALF_BIT);
  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam logic [BaudW-1:0] HalfLoad = BaudW'(CLK_PER_HALF_BIT - 1);
  localparam logic [BaudW-1:0] FullLoad = BaudW'(2 * CLK_PER_HALF_BIT - 1);
  localparam logic [BitW-1:0]  LastBit  = BitW'(DATA_BITS - 1);

  logic                 rx_meta_q, rx_s_q;
  rx_state_e            state_q;
  logic [BaudW-1:0]     baud_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q;
  logic                 frame_err_q, parity_err_q, overrun_err_q;

  logic tick, stop_tick, exp_par;
  logic push, fifo_full, fifo_empty;
  logic frame_set, parity_set, overrun_set;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick      = (baud_cnt_q == '0);
  assign stop_tick = (state_q == StStop) && tick;
  assign exp_par   = (PARITY == PAR_ODD) ? ~(^shift_q) : ^shift_q;

  // Receiver FSM with baud and bit counters; samples are taken at bit centres.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            baud_cnt_q <= HalfLoad;
            state_q    <= StStart;
          end
        end
        StStart: begin
          if (tick) begin
            if (!rx_s_q) begin
              baud_cnt_q <= FullLoad;
              bit_cnt_q  <= '0;
              par_bad_q  <= 1'b0;
              state_q    <= StData;
            end else begin
              state_q <= StIdle;  // start bit too short: treat as line glitch
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - BaudW'(1);
          end
        end
        StData: begin
          if (tick) begin
            shift_q    <= {rx_s_q, shift_q[DATA_BITS-1:1]};
            baud_cnt_q <= FullLoad;
            if (bit_cnt_q == LastBit) begin
              state_q <= (PARITY != PAR_NONE) ? StParity : StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + BitW'(1);
            end
          end else begin
            baud_cnt_q <= baud_cnt_q - BaudW'(1);
          end
        end
        StParity: begin
          if (tick) begin
            par_bad_q  <= (rx_s_q != exp_par);
            baud_cnt_q <= FullLoad;
            state_q    <= StStop;
          end else begin
            baud_cnt_q <= baud_cnt_q - BaudW'(1);
          end
        end
        StStop: begin
          // Leaving at mid-stop lets a start bit right after the stop sample be seen.
          if (tick) begin
            state_q <= rx_s_q ? StIdle : StBreak;
          end else begin
            baud_cnt_q <= baud_cnt_q - BaudW'(1);
          end
        end
        StBreak: begin
          if (rx_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign push        = stop_tick && rx_s_q && !par_bad_q;
  assign frame_set   = stop_tick && !rx_s_q;
  assign parity_set  = stop_tick && par_bad_q;
  assign overrun_set = push && fifo_full && !rd_ready;

  // Sticky error flags; a same-cycle set beats the clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      frame_err_q   <= frame_set   || (frame_err_q   && !err_clr);
      parity_err_q  <= parity_set  || (parity_err_q  && !err_clr);
      overrun_err_q <= overrun_set || (overrun_err_q && !err_clr);
    end
  end

  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overrun_err = overrun_err_q;
  assign rd_valid    = !fifo_empty;

  sync_fifo #(
    .DATA_W(DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data(shift_q),
    .pop      (rd_ready),
    .pop_data (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three receiver configurations driven by serial frame tasks, with
// a per-receiver queue of expected words checked as the consumer pops them.
module tb_uart_rx_fifo;

  localparam int unsigned Cphb   = 8;
  localparam int          BitCyc = 2 * Cphb;

  logic clk, rstn;
  logic rxd      [3];
  logic rd_ready [3];
  logic err_clr  [3];

  logic [7:0] d0_data, d1_data;
  logic [6:0] d2_data;
  logic [2:0] d0_cnt;
  logic [4:0] d1_cnt, d2_cnt;
  logic d0_valid, d1_valid, d2_valid;
  logic d0_ferr, d1_ferr, d2_ferr;
  logic d0_perr, d1_perr, d2_perr;
  logic d0_oerr, d1_oerr, d2_oerr;

  int unsigned data_w [3], cnt_w [3], valid_w [3], ferr_w [3], perr_w [3], oerr_w [3];
  int unsigned sb_q [3][$];
  int unsigned mon_exp;
  int n_cmp, n_bad;

  // 8N1, shallow FIFO for overrun
  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(Cphb), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4)
  ) u_dut0 (
    .clk(clk), .rstn(rstn), .rxd(rxd[0]), .rd_data(d0_data), .rd_valid(d0_valid),
    .rd_ready(rd_ready[0]), .fifo_count(d0_cnt), .frame_err(d0_ferr), .parity_err(d0_perr),
    .overrun_err(d0_oerr), .err_clr(err_clr[0])
  );

  // 8 bits, even parity
  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(Cphb), .DATA_BITS(8), .PARITY(1), .FIFO_DEPTH(16)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .rxd(rxd[1]), .rd_data(d1_data), .rd_valid(d1_valid),
    .rd_ready(rd_ready[1]), .fifo_count(d1_cnt), .frame_err(d1_ferr), .parity_err(d1_perr),
    .overrun_err(d1_oerr), .err_clr(err_clr[1])
  );

  // 7 bits, odd parity
  uart_rx_fifo #(
    .CLK_PER_HALF_BIT(Cphb), .DATA_BITS(7), .PARITY(2), .FIFO_DEPTH(16)
  ) u_dut2 (
    .clk(clk), .rstn(rstn), .rxd(rxd[2]), .rd_data(d2_data), .rd_valid(d2_valid),
    .rd_ready(rd_ready[2]), .fifo_count(d2_cnt), .frame_err(d2_ferr), .parity_err(d2_perr),
    .overrun_err(d2_oerr), .err_clr(err_clr[2])
  );

  always_comb begin
    data_w[0]  = {24'h0, d0_data};  data_w[1]  = {24'h0, d1_data};  data_w[2] = {25'h0, d2_data};
    cnt_w[0]   = {29'h0, d0_cnt};   cnt_w[1]   = {27'h0, d1_cnt};   cnt_w[2]  = {27'h0, d2_cnt};
    valid_w[0] = {31'h0, d0_valid}; valid_w[1] = {31'h0, d1_valid}; valid_w[2] = {31'h0, d2_valid};
    ferr_w[0]  = {31'h0, d0_ferr};  ferr_w[1]  = {31'h0, d1_ferr};  ferr_w[2]  = {31'h0, d2_ferr};
    perr_w[0]  = {31'h0, d0_perr};  perr_w[1]  = {31'h0, d1_perr};  perr_w[2]  = {31'h0, d2_perr};
    oerr_w[0]  = {31'h0, d0_oerr};  oerr_w[1]  = {31'h0, d1_oerr};  oerr_w[2]  = {31'h0, d2_oerr};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  function automatic logic xor_bits(input int unsigned d, input int n);
    logic r;
    r = 1'b0;
    for (int i = 0; i < n; i++) r ^= d[i];
    return r;
  endfunction

  // Hold one bit period; optionally check rd_valid before/after the expected stop sample.
  task automatic hold_bit(input int idx, input logic v, input int lo_at, input int hi_at);
    rxd[idx] = v;
    for (int c = 1; c <= BitCyc; c++) begin
      @(posedge clk);
      if (c == lo_at) begin
        @(negedge clk);
        check_eq("valid_before_stop_sample", valid_w[idx], 0);
      end
      if (c == hi_at) begin
        @(negedge clk);
        check_eq("valid_after_stop_sample", valid_w[idx], 1);
      end
    end
    #1;
  endtask

  task automatic send_frame(input int idx, input int unsigned data, input int nbits,
                            input bit use_par, input logic par_bit, input logic stop_bit,
                            input bit timed);
    hold_bit(idx, 1'b0, 0, 0);
    for (int i = 0; i < nbits; i++) hold_bit(idx, data[i], 0, 0);
    if (use_par) hold_bit(idx, par_bit, 0, 0);
    // Stop sample lands 11 cycles into the stop bit (2 sync + 1 detect + half bit).
    hold_bit(idx, stop_bit, timed ? 9 : 0, timed ? 12 : 0);
  endtask

  task automatic pulse_clr(input int idx);
    err_clr[idx] = 1'b1;
    step(1);
    err_clr[idx] = 1'b0;
  endtask

  // Scoreboard: every accepted pop must match the oldest expected word.
  always @(negedge clk) begin
    if (rstn) begin
      for (int i = 0; i < 3; i++) begin
        if (valid_w[i] != 0 && rd_ready[i]) begin
          mon_exp = (sb_q[i].size() > 0) ? sb_q[i].pop_front() : 32'hDEAD;
          check_eq($sformatf("pop_data_dut%0d", i), data_w[i], mon_exp);
        end
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rxd[i] = 1'b1; rd_ready[i] = 1'b0; err_clr[i] = 1'b0;
    end
    step(3);
    sample();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("rst_valid%0d", i), valid_w[i], 0);
      check_eq($sformatf("rst_count%0d", i), cnt_w[i], 0);
      check_eq($sformatf("rst_data%0d", i), data_w[i], 0);
      check_eq($sformatf("rst_ferr%0d", i), ferr_w[i], 0);
      check_eq($sformatf("rst_perr%0d", i), perr_w[i], 0);
      check_eq($sformatf("rst_oerr%0d", i), oerr_w[i], 0);
    end
    step(1);
    rstn = 1'b1;
    step(4);

    // 0xA5 on 8N1 with stop-sample timing, then a single pop
    sb_q[0].push_back(32'hA5);
    send_frame(0, 32'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1);
    sample();
    check_eq("a5_count", cnt_w[0], 1);
    check_eq("a5_head", data_w[0], 32'hA5);
    step(1);
    rd_ready[0] = 1'b1;
    step(1);
    rd_ready[0] = 1'b0;
    sample();
    check_eq("a5_valid_after_pop", valid_w[0], 0);
    check_eq("a5_count_after_pop", cnt_w[0], 0);
    step(1);

    // Short low pulse is rejected as a glitch
    rxd[0] = 1'b0;
    step(4);
    rxd[0] = 1'b1;
    step(32);
    sample();
    check_eq("glitch_count", cnt_w[0], 0);
    check_eq("glitch_ferr", ferr_w[0], 0);
    check_eq("glitch_perr", perr_w[0], 0);
    check_eq("glitch_oerr", oerr_w[0], 0);
    step(1);

    // Line held low for 40 bit periods: one frame error, nothing stored
    rd_ready[0] = 1'b1;
    rxd[0] = 1'b0;
    step(40 * BitCyc);
    sample();
    check_eq("break_ferr", ferr_w[0], 1);
    check_eq("break_count", cnt_w[0], 0);
    step(1);
    rxd[0] = 1'b1;
    step(32);
    pulse_clr(0);
    sample();
    check_eq("break_ferr_cleared", ferr_w[0], 0);
    step(1);
    sb_q[0].push_back(32'h5A);
    send_frame(0, 32'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8);
    sample();
    check_eq("after_break_count", cnt_w[0], 0);
    check_eq("after_break_ferr", ferr_w[0], 0);
    step(1);

    // Overrun: five words into a four-deep FIFO
    rd_ready[0] = 1'b0;
    for (int v = 'h10; v <= 'h13; v++) sb_q[0].push_back(v);
    for (int v = 'h10; v <= 'h14; v++) send_frame(0, v, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8);
    sample();
    check_eq("ovr_count", cnt_w[0], 4);
    check_eq("ovr_flag", oerr_w[0], 1);
    check_eq("ovr_head", data_w[0], 32'h10);
    step(1);
    rd_ready[0] = 1'b1;
    step(8);
    sample();
    check_eq("ovr_drained_count", cnt_w[0], 0);
    check_eq("ovr_drained_valid", valid_w[0], 0);
    step(1);
    rd_ready[0] = 1'b0;
    pulse_clr(0);
    sample();
    check_eq("ovr_flag_cleared", oerr_w[0], 0);
    step(1);

    // Even parity: wrong parity bit is dropped and flagged, correct one stored
    rd_ready[1] = 1'b1;
    send_frame(1, 32'h03, 8, 1'b1, ~xor_bits(32'h03, 8), 1'b1, 1'b0);
    step(8);
    sample();
    check_eq("par_bad_perr", perr_w[1], 1);
    check_eq("par_bad_ferr", ferr_w[1], 0);
    check_eq("par_bad_count", cnt_w[1], 0);
    step(1);
    pulse_clr(1);
    sample();
    check_eq("par_perr_cleared", perr_w[1], 0);
    step(1);
    sb_q[1].push_back(32'h03);
    send_frame(1, 32'h03, 8, 1'b1, xor_bits(32'h03, 8), 1'b1, 1'b0);
    step(8);
    sample();
    check_eq("par_good_perr", perr_w[1], 0);
    check_eq("par_good_count", cnt_w[1], 0);
    step(1);

    // Back-to-back 7O1 frames; the first word is popped on the second word's push edge
    sb_q[2].push_back(32'h7F);
    sb_q[2].push_back(32'h00);
    send_frame(2, 32'h7F, 7, 1'b1, ~xor_bits(32'h7F, 7), 1'b1, 1'b0);
    fork
      send_frame(2, 32'h00, 7, 1'b1, ~xor_bits(32'h00, 7), 1'b1, 1'b0);
      begin
        repeat (154) @(posedge clk);
        #1;
        rd_ready[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("b2b_count_push_pop", cnt_w[2], 1);
        check_eq("b2b_new_head", data_w[2], 32'h00);
      end
    join
    step(8);
    sample();
    check_eq("b2b_count_end", cnt_w[2], 0);
    check_eq("b2b_ferr", ferr_w[2], 0);
    check_eq("b2b_perr", perr_w[2], 0);
    check_eq("b2b_oerr", oerr_w[2], 0);
    step(1);

    // Reset in mid-frame abandons it; the next frame is received normally
    rd_ready[0] = 1'b1;
    hold_bit(0, 1'b0, 0, 0);
    hold_bit(0, 1'b1, 0, 0);
    hold_bit(0, 1'b0, 0, 0);
    rstn   = 1'b0;
    rxd[0] = 1'b1;
    step(3);
    sample();
    check_eq("midrst_count", cnt_w[0], 0);
    check_eq("midrst_valid", valid_w[0], 0);
    step(1);
    rstn = 1'b1;
    step(4);
    sb_q[0].push_back(32'h3C);
    send_frame(0, 32'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8);
    sample();
    check_eq("midrst_after_count", cnt_w[0], 0);
    check_eq("midrst_after_ferr", ferr_w[0], 0);
    step(1);

    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("sb_left_dut%0d", i), sb_q[i].size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
